oled_glyph_sequencer: RTL

OLED_GLYPH_SEQUENCER -- requirements
Module: oled_glyph_sequencer

---
 rtl/oled_glyph_sequencer.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/oled_glyph_sequencer.sv
// -----------------------------------------------------------------------------
// oled_glyph_sequencer
//
// Renders a line of 16-pixel-high glyphs onto a page-addressed OLED.
// Glyph codes are loaded into a small buffer. A start request then walks
// glyphs 0..num-1. For each glyph and each half (upper page, then lower page)
// the block emits a page-address command and two column-address commands.
// It then fetches W bytes from an external font ROM that has a registered
// read, and forwards each byte to a valid/ready OLED bus writer.
//
// Optional feature macro: OLED_SEQ_BLANK_EN
//   When defined, code 6'h3F is a blank 8-wide glyph. Its data bytes are
//   0x00 and are produced without any ROM fetch. The commands are still
//   sent. When undefined, 6'h3F is an ordinary ROM glyph.
//
// Ports
//   sys_clk, rst_n       clock, asynchronous active-low reset
//   buf_wr/addr/code     glyph buffer write port (ignored while busy)
//   start                render request pulse
//   num_glyphs/page/col  render parameters, latched on an accepted start
//   font_sel/row/index   font ROM address (registered)
//   font_data            font ROM read data, valid 1 cycle after the address
//   out_valid/dc/byte    byte stream to the OLED writer (dc: 0=cmd, 1=data)
//   out_ready            writer accepts the current byte
//   busy, done, err      render status; err is held until the next start
// -----------------------------------------------------------------------------
module oled_glyph_sequencer #(
  parameter int MAX_GLYPHS = 8
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       buf_wr,
  input  logic [2:0] buf_addr,
  input  logic [5:0] buf_code,
  input  logic       start,
  input  logic [3:0] num_glyphs,
  input  logic [2:0] page,
  input  logic [6:0] col,
  output logic [5:0] font_sel,
  output logic       font_row,
  output logic [8:0] index,
  input  logic [7:0] font_data,
  output logic       out_valid,
  output logic       out_dc,
  output logic [7:0] out_byte,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CMD_PG = 4'd1;
  localparam logic [3:0] S_CMD_CL = 4'd2;
  localparam logic [3:0] S_CMD_CH = 4'd3;
  localparam logic [3:0] S_ADDR   = 4'd4;
  localparam logic [3:0] S_LAT    = 4'd5;
  localparam logic [3:0] S_SEND   = 4'd6;
  localparam logic [3:0] S_NEXT   = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  localparam logic [3:0] MAX_N = 4'(MAX_GLYPHS);

`ifdef OLED_SEQ_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  logic [3:0] state;
  logic [5:0] glyph_buf [MAX_GLYPHS];

  // Latched render context
  logic [3:0] num_l;
  logic [2:0] page_l;
  logic [7:0] c;        // current glyph column; may reach 128 after the last glyph
  logic [3:0] g;        // current glyph number
  logic       half;     // 0 = upper page, 1 = lower page
  logic [4:0] bidx;     // data byte number within the current half

  logic       accept;
  logic [5:0] cur_code;
  logic [4:0] cur_w;
  logic       blank;
  logic [8:0] end_col;
  logic       fits;
  logic       last_byte;

  // Glyph width: codes 4..9 and 11 are double width.
  function automatic logic [4:0] glyph_w(input logic [5:0] code);
    if (((code >= 6'd4) && (code <= 6'd9)) || (code == 6'd11)) begin
      return 5'd16;
    end
    return 5'd8;
  endfunction

  // A start landing on the done-pulse cycle is deliberately dropped. This
  // stops a requester that restarts on done from racing the status update.
  assign accept    = (state == S_IDLE) && start && !busy && !done;

  assign cur_code  = glyph_buf[g[2:0]];
  assign cur_w     = glyph_w(cur_code);
  assign blank     = BLANK_EN && (cur_code == 6'h3F);
  assign end_col   = {1'b0, c} + {4'b0, cur_w};
  assign fits      = (end_col <= 9'd128);
  assign last_byte = (bidx == (cur_w - 5'd1));

  // Glyph buffer. It is frozen while a render is running, so the codes stay
  // consistent for the whole line.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_GLYPHS; i++) begin
        glyph_buf[i] <= '0;
      end
    end else if (buf_wr && !busy && !accept && ({1'b0, buf_addr} < MAX_N)) begin
      glyph_buf[buf_addr] <= buf_code;
    end
  end

  // Sequencer. Output bytes are registered. Every transition into a
  // CMD_* or SEND state loads the byte that state presents, so out_* only
  // change on an accepted handshake or on entry.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_dc    <= 1'b0;
      out_byte  <= 8'h00;
      font_sel  <= 6'd0;
      font_row  <= 1'b0;
      index     <= 9'd0;
      num_l     <= 4'd0;
      page_l    <= 3'd0;
      c         <= 8'd0;
      g         <= 4'd0;
      half      <= 1'b0;
      bidx      <= 5'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            busy   <= 1'b1;
            num_l  <= (num_glyphs > MAX_N) ? MAX_N : num_glyphs;
            page_l <= page;
            c      <= {1'b0, col};
            g      <= 4'd0;
            half   <= 1'b0;
            bidx   <= 5'd0;
            err    <= (num_glyphs > MAX_N) || (page == 3'd7);
            // page 7 has no page below it for the lower half.
            if ((page == 3'd7) || (num_glyphs == 4'd0)) begin
              state <= S_FIN;
            end else begin
              state <= S_NEXT;
            end
          end
        end

        // Decide whether the next glyph exists and fits on the line.
        S_NEXT: begin
          if (g == num_l) begin
            state <= S_FIN;
          end else if (!fits) begin
            err   <= 1'b1;
            state <= S_FIN;
          end else begin
            out_valid <= 1'b1;
            out_dc    <= 1'b0;
            out_byte  <= {5'b10110, page_l + {2'b00, half}};
            state     <= S_CMD_PG;
          end
        end

        S_CMD_PG: begin
          if (out_ready) begin
            out_byte <= {4'h0, c[3:0]};
            state    <= S_CMD_CL;
          end
        end

        S_CMD_CL: begin
          if (out_ready) begin
            out_byte <= {5'b00010, c[6:4]};
            state    <= S_CMD_CH;
          end
        end

        S_CMD_CH: begin
          if (out_ready) begin
            bidx <= 5'd0;
            if (blank) begin
              out_dc   <= 1'b1;
              out_byte <= 8'h00;
              state    <= S_SEND;
            end else begin
              out_valid <= 1'b0;
              font_sel  <= cur_code;
              font_row  <= half;
              index     <= 9'd0;
              state     <= S_ADDR;
            end
          end
        end

        // ROM sees the address this cycle and registers its read at the edge.
        S_ADDR: begin
          state <= S_LAT;
        end

        // ROM data is valid this cycle. Capture it as the next output byte.
        S_LAT: begin
          out_valid <= 1'b1;
          out_dc    <= 1'b1;
          out_byte  <= font_data;
          state     <= S_SEND;
        end

        S_SEND: begin
          if (out_ready) begin
            if (last_byte) begin
              if (!half) begin
                half      <= 1'b1;
                out_valid <= 1'b1;
                out_dc    <= 1'b0;
                out_byte  <= {5'b10110, page_l + 3'd1};
                state     <= S_CMD_PG;
              end else begin
                half      <= 1'b0;
                c         <= c + {3'b000, cur_w};
                g         <= g + 4'd1;
                out_valid <= 1'b0;
                out_dc    <= 1'b0;
                state     <= S_NEXT;
              end
            end else begin
              bidx <= bidx + 5'd1;
              if (blank) begin
                out_byte <= 8'h00;
              end else begin
                out_valid <= 1'b0;
                index     <= {4'b0000, bidx + 5'd1};
                state     <= S_ADDR;
              end
            end
          end
        end

        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
